// File: rtl/regread_pkg.sv
// Shared types and constants for the register-read stage.
//
// Contents:
//   ISSUE_W, WB_W, NPREGS, PREG_W, XLEN, UOP_W  geometry of the stage
//   preg_t / xlen_t / uop_t                     index, operand and payload types
//   ZERO_PREG                                   hard-wired zero register
//   wb_match_sel()                              one-hot pick of the winning writeback port
package regread_pkg;

  localparam int ISSUE_W = 3;
  localparam int WB_W    = 3;
  localparam int NPREGS  = 80;
  localparam int PREG_W  = $clog2(NPREGS);
  localparam int XLEN    = 64;
  localparam int UOP_W   = 32;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [XLEN-1:0]   xlen_t;
  typedef logic [UOP_W-1:0]  uop_t;

  localparam preg_t ZERO_PREG = '0;

  // Returns a one-hot vector marking the highest-index valid writeback port
  // whose address equals preg, or all zeros if none match. Highest index wins
  // because the regfile commits same-address writes in that order.
  function automatic logic [WB_W-1:0] wb_match_sel(
    input preg_t                   preg,
    input logic [WB_W-1:0]         wb_valid,
    input logic [WB_W*PREG_W-1:0]  wb_addr
  );
    logic [WB_W-1:0] sel;
    sel = '0;
    for (int w = 0; w < WB_W; w++) begin
      if (wb_valid[w] && (wb_addr[w*PREG_W +: PREG_W] == preg)) begin
        sel    = '0;
        sel[w] = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regread_bypass_mux.sv
// Operand select for a single source operand.
//
// Configuration macro: REGREAD_WB_BYPASS_EN
//   defined   : same-cycle writeback data overrides the regfile read data
//   undefined : operand is the regfile read data; wb_* inputs are ignored
// Preg 0 always reads as zero in both builds.
//
// Ports:
//   preg      in   source physical register
//   rf_rdata  in   regfile read data for this operand
//   wb_valid  in   writeback port valids
//   wb_addr   in   writeback port addresses
//   wb_data   in   writeback port data
//   operand   out  selected operand value
module regread_bypass_mux
  import regread_pkg::*;
(
  input  preg_t                   preg,
  input  xlen_t                   rf_rdata,
  input  logic [WB_W-1:0]         wb_valid,
  input  logic [WB_W*PREG_W-1:0]  wb_addr,
  input  logic [WB_W*XLEN-1:0]    wb_data,
  output xlen_t                   operand
);

`ifdef REGREAD_WB_BYPASS_EN
  logic [WB_W-1:0] sel;

  assign sel = wb_match_sel(preg, wb_valid, wb_addr);

  always_comb begin
    operand = rf_rdata;
    for (int w = 0; w < WB_W; w++) begin
      if (sel[w]) operand = wb_data[w*XLEN +: XLEN];
    end
    if (preg == ZERO_PREG) operand = '0;
  end
`else
  // Writeback ports stay on the interface so both builds share one netlist
  // boundary; without bypass issue delays wakeup by a cycle instead.
  logic unused_wb;

  assign unused_wb = ^{wb_valid, wb_addr, wb_data};
  assign operand   = (preg == ZERO_PREG) ? '0 : rf_rdata;
`endif

endmodule

// File: rtl/regread_stage.sv
// Register-read pipeline stage between issue and execute.
// Sole read client of the physical integer regfile: drives 2*ISSUE_W async
// read ports, optionally bypasses same-cycle writeback data, and registers
// operands plus uop payload for execute. Single-entry pipe with no skid;
// a whole issue group moves together.
//
// Configuration macro: REGREAD_WB_BYPASS_EN (see regread_bypass_mux).
//
// Ports:
//   clock, reset      clock, synchronous active-high reset
//   flush             kill the held group and drop this cycle's input
//   in_valid/ready    per-lane valid, group ready
//   in_prs1/2, in_uop source pregs and payload per lane
//   rf_ren/raddr      regfile read enables / addresses (2i = rs1, 2i+1 = rs2)
//   rf_rdata          regfile read data (combinational)
//   wb_valid/addr/data writeback snoop, same cycle as regfile write enable
//   out_valid/ready   per-lane output valid, group ready from execute
//   out_uop/rs1/rs2   registered payload and operands
module regread_stage
  import regread_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic [ISSUE_W-1:0]            in_valid,
  output logic                          in_ready,
  input  logic [ISSUE_W*PREG_W-1:0]     in_prs1,
  input  logic [ISSUE_W*PREG_W-1:0]     in_prs2,
  input  logic [ISSUE_W*UOP_W-1:0]      in_uop,
  output logic [2*ISSUE_W-1:0]          rf_ren,
  output logic [2*ISSUE_W*PREG_W-1:0]   rf_raddr,
  input  logic [2*ISSUE_W*XLEN-1:0]     rf_rdata,
  input  logic [WB_W-1:0]               wb_valid,
  input  logic [WB_W*PREG_W-1:0]        wb_addr,
  input  logic [WB_W*XLEN-1:0]          wb_data,
  output logic [ISSUE_W-1:0]            out_valid,
  input  logic                          out_ready,
  output logic [ISSUE_W*UOP_W-1:0]      out_uop,
  output logic [ISSUE_W*XLEN-1:0]       out_rs1,
  output logic [ISSUE_W*XLEN-1:0]       out_rs2
);

  logic                           accept;
  logic [ISSUE_W-1:0][XLEN-1:0]   opnd_rs1;
  logic [ISSUE_W-1:0][XLEN-1:0]   opnd_rs2;

  assign in_ready = ~|out_valid | out_ready;
  assign accept   = in_ready & |in_valid & ~flush;

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_lane
    // Reads are only enabled when the data can actually be captured.
    assign rf_ren[2*i]   = in_valid[i] & in_ready & ~flush;
    assign rf_ren[2*i+1] = in_valid[i] & in_ready & ~flush;

    assign rf_raddr[(2*i)*PREG_W   +: PREG_W] = in_prs1[i*PREG_W +: PREG_W];
    assign rf_raddr[(2*i+1)*PREG_W +: PREG_W] = in_prs2[i*PREG_W +: PREG_W];

    regread_bypass_mux u_mux_rs1 (
      .preg     (in_prs1[i*PREG_W +: PREG_W]),
      .rf_rdata (rf_rdata[(2*i)*XLEN +: XLEN]),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .operand  (opnd_rs1[i])
    );

    regread_bypass_mux u_mux_rs2 (
      .preg     (in_prs2[i*PREG_W +: PREG_W]),
      .rf_rdata (rf_rdata[(2*i+1)*XLEN +: XLEN]),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .operand  (opnd_rs2[i])
    );
  end

  // Held data is never refreshed while stalled: rename keeps the source pregs
  // stable until the consumer leaves this stage.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= '0;
      out_uop   <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
    end else if (flush) begin
      out_valid <= '0;
    end else if (accept) begin
      out_valid <= in_valid;
      for (int i = 0; i < ISSUE_W; i++) begin
        if (in_valid[i]) begin
          out_uop[i*UOP_W +: UOP_W] <= in_uop[i*UOP_W +: UOP_W];
          out_rs1[i*XLEN +: XLEN]   <= opnd_rs1[i];
          out_rs2[i*XLEN +: XLEN]   <= opnd_rs2[i];
        end else begin
          out_uop[i*UOP_W +: UOP_W] <= '0;
          out_rs1[i*XLEN +: XLEN]   <= '0;
          out_rs2[i*XLEN +: XLEN]   <= '0;
        end
      end
    end else if (out_ready) begin
      out_valid <= '0;
    end
  end

`ifndef SYNTHESIS
  // Out-of-range pregs still go to the regfile unchanged; flag them here.
  always @(posedge clock) begin
    if (!reset && !flush) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (in_valid[i]) begin
          assert (int'(in_prs1[i*PREG_W +: PREG_W]) < NPREGS)
            else $error("regread_stage: lane %0d prs1 out of range", i);
          assert (int'(in_prs2[i*PREG_W +: PREG_W]) < NPREGS)
            else $error("regread_stage: lane %0d prs2 out of range", i);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_regread_stage.sv
module tb_regread_stage;
  import regread_pkg::*;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic [2:0]   in_valid;
  logic         in_ready;
  logic [20:0]  in_prs1;
  logic [20:0]  in_prs2;
  logic [95:0]  in_uop;
  logic [5:0]   rf_ren;
  logic [41:0]  rf_raddr;
  logic [383:0] rf_rdata;
  logic [2:0]   wb_valid;
  logic [20:0]  wb_addr;
  logic [191:0] wb_data;
  logic [2:0]   out_valid;
  logic         out_ready;
  logic [95:0]  out_uop;
  logic [191:0] out_rs1;
  logic [191:0] out_rs2;

  always #5 clock = ~clock;

  regread_stage dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prs1   (in_prs1),
    .in_prs2   (in_prs2),
    .in_uop    (in_uop),
    .rf_ren    (rf_ren),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .wb_valid  (wb_valid),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_uop   (out_uop),
    .out_rs1   (out_rs1),
    .out_rs2   (out_rs2)
  );

  // Reference: architectural regfile contents plus a queue of groups that
  // have been accepted but not yet taken by execute.
  typedef struct {
    logic [2:0]   v;
    logic [95:0]  uop;
    logic [191:0] rs1;
    logic [191:0] rs2;
  } grp_t;

  logic [63:0] mem [NPREGS];
  grp_t        q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_accepted = 0;
  bit          was_reset;

  task automatic chk(input string tag, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Operand value as seen by a consumer reading preg p this cycle.
  function automatic logic [63:0] model_opnd(input logic [6:0] p);
    logic [63:0] v;
    if (p == 7'd0) return 64'h0;
    v = mem[p];
`ifdef REGREAD_WB_BYPASS_EN
    for (int w = 0; w < 3; w++)
      if (wb_valid[w] && wb_addr[w*7 +: 7] == p) v = wb_data[w*64 +: 64];
`endif
    return v;
  endfunction

  function automatic logic [6:0] rnd_preg();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 7'd0;
    if (r < 4)  return 7'($urandom_range(1, 12));
    return 7'($urandom_range(1, NPREGS-1));
  endfunction

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 3'b000;
    in_prs1   = '0;
    in_prs2   = '0;
    in_uop    = '0;
    wb_valid  = 3'b000;
    wb_addr   = '0;
    wb_data   = '0;
    out_ready = 1'b1;
  endtask

  task automatic rnd_inputs(input bit allow_flush);
    in_valid = 3'($urandom_range(0, 7));
    for (int i = 0; i < 3; i++) begin
      in_prs1[i*7 +: 7]   = rnd_preg();
      in_prs2[i*7 +: 7]   = rnd_preg();
      in_uop[i*32 +: 32]  = $urandom;
      wb_addr[i*7 +: 7]   = rnd_preg();
      wb_data[i*64 +: 64] = {$urandom, $urandom};
    end
    wb_valid  = 3'($urandom_range(0, 7));
    out_ready = ($urandom_range(0, 3) != 0);
    flush     = allow_flush && ($urandom_range(0, 31) == 0);
  endtask

  // One clock: regfile read data, combinational checks, model update, edge,
  // regfile write, registered-output checks. Inputs are set by the caller.
  task automatic cycle();
    logic       exp_rdy;
    logic [5:0] exp_ren;
    logic [41:0] exp_raddr;
    logic [2:0] exp_v;
    grp_t       g;
    for (int i = 0; i < 3; i++) begin
      rf_rdata[(2*i)*64 +: 64]   = mem[in_prs1[i*7 +: 7]];
      rf_rdata[(2*i+1)*64 +: 64] = mem[in_prs2[i*7 +: 7]];
    end
    #1;
    if (!reset) begin
      exp_rdy = (q.size() == 0) || out_ready;
      for (int i = 0; i < 3; i++) begin
        exp_ren[2*i]   = in_valid[i] & exp_rdy & ~flush;
        exp_ren[2*i+1] = in_valid[i] & exp_rdy & ~flush;
        exp_raddr[(2*i)*7 +: 7]   = in_prs1[i*7 +: 7];
        exp_raddr[(2*i+1)*7 +: 7] = in_prs2[i*7 +: 7];
      end
      chk("in_ready", 96'(in_ready), 96'(exp_rdy));
      chk("rf_ren", 96'(rf_ren), 96'(exp_ren));
      chk("rf_raddr", 96'(rf_raddr), 96'(exp_raddr));
      if (flush) begin
        q.delete();
      end else begin
        if (q.size() != 0 && out_ready) q.delete(0);
        if (exp_rdy && in_valid != 3'b000) begin
          g.v = in_valid;
          g.uop = '0; g.rs1 = '0; g.rs2 = '0;
          for (int i = 0; i < 3; i++) begin
            if (in_valid[i]) begin
              g.uop[i*32 +: 32] = in_uop[i*32 +: 32];
              g.rs1[i*64 +: 64] = model_opnd(in_prs1[i*7 +: 7]);
              g.rs2[i*64 +: 64] = model_opnd(in_prs2[i*7 +: 7]);
            end
          end
          q.push_back(g);
          n_accepted++;
        end
      end
    end else begin
      q.delete();
    end
    was_reset = reset;
    @(posedge clock);
    #1;
    for (int w = 0; w < 3; w++)
      if (wb_valid[w]) mem[wb_addr[w*7 +: 7]] = wb_data[w*64 +: 64];
    exp_v = (q.size() != 0) ? q[0].v : 3'b000;
    chk("out_valid", 96'(out_valid), 96'(exp_v));
    if (q.size() != 0) begin
      chk("out_uop", out_uop, q[0].uop);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("out_rs1_l%0d", i), 96'(out_rs1[i*64 +: 64]), 96'(q[0].rs1[i*64 +: 64]));
        chk($sformatf("out_rs2_l%0d", i), 96'(out_rs2[i*64 +: 64]), 96'(q[0].rs2[i*64 +: 64]));
      end
    end
    if (was_reset) begin
      chk("rst_uop", out_uop, 96'h0);
      chk("rst_rs1", 96'(out_rs1[191:96]), 96'h0);
      chk("rst_rs1b", out_rs1[95:0], 96'h0);
      chk("rst_rs2", 96'(out_rs2[191:96]), 96'h0);
      chk("rst_rs2b", out_rs2[95:0], 96'h0);
    end
  endtask

  initial begin
    logic [63:0] exp_byp;
    for (int i = 0; i < NPREGS; i++) mem[i] = {$urandom, $urandom};
    rf_rdata = '0;
    idle_inputs();
    reset = 1'b1;

    // 1. reset, then idle
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    chk("t1_in_ready", 96'(in_ready), 96'd1);
    chk("t1_rf_ren", 96'(rf_ren), 96'd0);
    chk("t1_out_valid", 96'(out_valid), 96'd0);

    // 2. lane0 simple read, rs2 = preg 0
    in_valid = 3'b001;
    in_prs1[6:0] = 7'd5;
    in_prs2[6:0] = 7'd0;
    in_uop[31:0] = 32'hC0DE_0001;
    mem[5] = 64'hAA;
    cycle();
    chk("t2_valid", 96'(out_valid), 96'b001);
    chk("t2_rs1", 96'(out_rs1[63:0]), 96'hAA);
    chk("t2_rs2", 96'(out_rs2[63:0]), 96'h0);

    // 3. lane1 bypass, two wb ports hitting the same preg
    idle_inputs();
    in_valid = 3'b010;
    in_prs1[13:7] = 7'd9;
    in_prs2[13:7] = 7'd3;
    in_uop[63:32] = 32'hC0DE_0002;
    mem[9] = 64'h99;
    wb_valid = 3'b101;
    wb_addr  = {7'd9, 7'd40, 7'd9};
    wb_data  = {64'h22, 64'h33, 64'h11};
`ifdef REGREAD_WB_BYPASS_EN
    exp_byp = 64'h22;
`else
    exp_byp = 64'h99;
`endif
    cycle();
    chk("t3_valid", 96'(out_valid), 96'b010);
    chk("t3_rs1_l1", 96'(out_rs1[127:64]), 96'(exp_byp));

    // 4. full group, then 4 stall cycles with changing regfile/wb
    rnd_inputs(1'b0);
    in_valid  = 3'b111;
    out_ready = 1'b1;
    cycle();
    for (int k = 0; k < 4; k++) begin
      rnd_inputs(1'b0);
      in_valid  = 3'b111;
      out_ready = 1'b0;
      cycle();
      chk("t4_stall_in_ready", 96'(in_ready), 96'd0);
    end
    idle_inputs();
    cycle();
    chk("t4_drained", 96'(out_valid), 96'd0);

    // 5. flush during a stall with all lanes presented
    rnd_inputs(1'b0);
    in_valid = 3'b111; out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    cycle();
    flush = 1'b1;
    cycle();
    chk("t5_flushed", 96'(out_valid), 96'd0);
    rnd_inputs(1'b0);
    in_valid = 3'b011; out_ready = 1'b1;
    cycle();
    chk("t5_latency", 96'(out_valid), 96'b011);

    // reset in the middle of a stall
    rnd_inputs(1'b0);
    in_valid = 3'b111; out_ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    idle_inputs();
    cycle();

    // 6. random traffic
    for (int n = 0; n < 3000; n++) begin
      rnd_inputs(1'b1);
      cycle();
    end
    idle_inputs();
    cycle();
    chk("t6_drained", 96'(out_valid), 96'd0);
    chk("t6_traffic", 96'(n_accepted > 500), 96'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
